pubexp_select: RTL
==================

Name: pubexp_select

Overview:
- Upstream driver and downstream consumer of the GCD stage in RSA key generation.
- Given phi = (p-1)(q-1), it walks odd candidate public exponents e upward from E_START.
- For each candidate it launches one gcd(phi, e) run and consumes the result.
- Reports the first e with gcd == 1, or a failure.

Parameters:
- WIDTH, 8, bit width of phi, e and the GCD operands; must match the attached GCD instance.
- E_START, 3, first candidate exponent; bit 0 is forced to 1, so the effective start is E_START|1.
- MAX_TRIES, 16, maximum number of GCD runs per request before failure; must be ≥1 and ≤ 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- phi  input  WIDTH  totient; sampled on accepted start.
- e_out  output  WIDTH  selected exponent.
- tries  output  WIDTH  number of GCD runs issued for the current/last request.
- finish  output  1  one-cycle pulse: success; e_out is valid.
- fail  output  1  one-cycle pulse: no exponent found.
- busy  output  1  high while in CALC.
- gcd_start  output  1  one-cycle launch pulse to the GCD stage.
- gcd_a  output  WIDTH  bigger operand to GCD (always phi).
- gcd_b  output  WIDTH  smaller operand to GCD (current candidate).
- gcd_result  input  WIDTH  GCD value; valid only when gcd_finish is high.
- gcd_finish  input  1  one-cycle GCD completion pulse.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. The clock is clk and the reset is rst.
- Reset values: all outputs are 0, state = IDLE, internal phi_r = 0, cand = 0.
- All outputs are registered, using next-state logic plus a single sequential block.

States:
- IDLE.
  - start=1 with (E_START|1) < phi:
    - Latch phi_r = phi, cand = E_START|1, tries = 1.
    - Drive gcd_a = phi, gcd_b = E_START|1, and gcd_start = 1 in the next cycle (cycle T+1 for start at T).
    - Clear e_out to 0.
    - Go to CALC.
  - start=1 with (E_START|1) ≥ phi:
    - Pulse fail at T+1, set tries = 0, stay in IDLE.
    - gcd_start is never asserted.
  - start=0: hold all registers.
- CALC (busy=1). Wait for gcd_finish; on gcd_finish at cycle F:
  - gcd_result == 1:
    - e_out = cand, finish=1 at F+1.
    - Go to IDLE.
  - gcd_result != 1:
    - Compute nxt = cand + 2 in WIDTH+1 bits.
    - If nxt ≥ phi_r, or carry out, or tries == MAX_TRIES: fail=1 at F+1, go to IDLE, e_out stays 0.
    - Otherwise: cand = nxt, gcd_b = nxt, tries += 1, gcd_start=1 at F+1, stay in CALC.

Operand and output holding:
- gcd_a and gcd_b hold stable from the gcd_start cycle until the next launch.
- gcd_a/gcd_b are cleared to 0 on return to IDLE.
- e_out and tries hold their last values in IDLE until the next accepted start.

Boundary conditions:
- Exactly one gcd_start per outstanding GCD run; never two launches without an intervening gcd_finish.
- gcd_b is always odd, ≥1 and < gcd_a, which satisfies the GCD stage's ordering and nonzero-divisor requirements.
- start while busy is ignored; phi is not re-sampled.
- gcd_finish in IDLE (a stale result after reset) is ignored, with no output change.
- gcd_result == 0 is treated as != 1.
- finish and fail are never high together, and each is high for exactly one cycle.
- rst mid-CALC: immediate return to IDLE with all outputs 0. No further gcd_start is issued until a new start.

Test Plan:
- E_START=3, phi=20, start pulse → gcd_start at T+1 with a=20, b=3; gcd returns 1 → finish pulse, e_out=3, tries=1, busy falls.
- phi=60 → launches b=3 (gcd 3), b=5 (gcd 5), b=7 (gcd 1); each relaunch is 1 cycle after gcd_finish → e_out=7, tries=3.
- phi=3 (≤ E_START|1) → fail pulse at T+1, no gcd_start, tries=0, e_out=0.
- MAX_TRIES=2, phi=105 → b=3 (gcd 3), b=5 (gcd 5) → fail pulse, tries=2, no third gcd_start.
- start asserted again while busy with phi=50 during the phi=60 run → ignored; result is still e_out=7; gcd_a stays 60 throughout.
- rst asserted mid-CALC, then a late gcd_finish with result 1 → all outputs 0 immediately; late finish ignored. A subsequent start with phi=20 yields e_out=3.

Source files
------------

// File: rtl/pubexp_select_if.sv
// Request/response and GCD-stage handshake bundle for pubexp_select.
// slave = the selector itself; master = whoever drives requests and answers GCD runs.
interface pubexp_select_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] phi;
  logic [WIDTH-1:0] e_out;
  logic [WIDTH-1:0] tries;
  logic             finish;
  logic             fail;
  logic             busy;
  logic             gcd_start;
  logic [WIDTH-1:0] gcd_a;
  logic [WIDTH-1:0] gcd_b;
  logic [WIDTH-1:0] gcd_result;
  logic             gcd_finish;

  modport slave (
    input  start, phi, gcd_result, gcd_finish,
    output e_out, tries, finish, fail, busy, gcd_start, gcd_a, gcd_b
  );

  modport master (
    output start, phi, gcd_result, gcd_finish,
    input  e_out, tries, finish, fail, busy, gcd_start, gcd_a, gcd_b
  );
endinterface

// File: rtl/pubexp_select.sv
// Walks odd public-exponent candidates upward from E_START, launching one
// gcd(phi, e) run per candidate and reporting the first coprime e or a failure.
module pubexp_select #(
  parameter int WIDTH     = 8,
  parameter int E_START   = 3,
  parameter int MAX_TRIES = 16
) (
  input  logic          clk,
  input  logic          rst,
  pubexp_select_if.slave bus
);
  localparam logic [WIDTH-1:0] E_ODD = WIDTH'(E_START) | WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_T = WIDTH'(MAX_TRIES);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] phi_q, phi_n;
  logic [WIDTH-1:0] cand_q, cand_n;
  logic [WIDTH-1:0] e_out_q, e_out_n;
  logic [WIDTH-1:0] tries_q, tries_n;
  logic [WIDTH-1:0] gcd_a_q, gcd_a_n;
  logic [WIDTH-1:0] gcd_b_q, gcd_b_n;
  logic             finish_q, finish_n;
  logic             fail_q, fail_n;
  logic             busy_q, busy_n;
  logic             gcd_start_q, gcd_start_n;
  logic [WIDTH:0]   nxt;

  always_comb begin
    state_n     = state_q;
    phi_n       = phi_q;
    cand_n      = cand_q;
    e_out_n     = e_out_q;
    tries_n     = tries_q;
    gcd_a_n     = gcd_a_q;
    gcd_b_n     = gcd_b_q;
    finish_n    = 1'b0;
    fail_n      = 1'b0;
    gcd_start_n = 1'b0;
    // one extra bit so a wrap past 2^WIDTH-1 shows up as a carry
    nxt         = {1'b0, cand_q} + (WIDTH+1)'(2);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // a rejected request also clears e_out so a fail never shows a stale exponent
          e_out_n = '0;
          if (E_ODD < bus.phi) begin
            phi_n       = bus.phi;
            cand_n      = E_ODD;
            tries_n     = WIDTH'(1);
            gcd_a_n     = bus.phi;
            gcd_b_n     = E_ODD;
            gcd_start_n = 1'b1;
            state_n     = CALC;
          end else begin
            tries_n = '0;
            fail_n  = 1'b1;
          end
        end
      end
      CALC: begin
        if (bus.gcd_finish) begin
          if (bus.gcd_result == WIDTH'(1)) begin
            e_out_n  = cand_q;
            finish_n = 1'b1;
            gcd_a_n  = '0;
            gcd_b_n  = '0;
            state_n  = IDLE;
          end else if (nxt >= {1'b0, phi_q} || nxt[WIDTH] || tries_q == MAX_T) begin
            fail_n  = 1'b1;
            gcd_a_n = '0;
            gcd_b_n = '0;
            state_n = IDLE;
          end else begin
            cand_n      = nxt[WIDTH-1:0];
            gcd_b_n     = nxt[WIDTH-1:0];
            tries_n     = tries_q + WIDTH'(1);
            gcd_start_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == CALC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phi_q       <= '0;
      cand_q      <= '0;
      e_out_q     <= '0;
      tries_q     <= '0;
      gcd_a_q     <= '0;
      gcd_b_q     <= '0;
      finish_q    <= 1'b0;
      fail_q      <= 1'b0;
      busy_q      <= 1'b0;
      gcd_start_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      phi_q       <= phi_n;
      cand_q      <= cand_n;
      e_out_q     <= e_out_n;
      tries_q     <= tries_n;
      gcd_a_q     <= gcd_a_n;
      gcd_b_q     <= gcd_b_n;
      finish_q    <= finish_n;
      fail_q      <= fail_n;
      busy_q      <= busy_n;
      gcd_start_q <= gcd_start_n;
    end
  end

  assign bus.e_out     = e_out_q;
  assign bus.tries     = tries_q;
  assign bus.finish    = finish_q;
  assign bus.fail      = fail_q;
  assign bus.busy      = busy_q;
  assign bus.gcd_start = gcd_start_q;
  assign bus.gcd_a     = gcd_a_q;
  assign bus.gcd_b     = gcd_b_q;
endmodule
